// File: rtl/v1_param.sv
// Shared widths and FSM state encoding for the v1 pulse-processing chain.
package v1_param;

    localparam int SIZE_FILTER_DATA = 18;
    localparam int SIZE_PEAK_TS     = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } peak_state_e;

endpackage

// File: rtl/v1_peak_finder_if.sv
// Sample-in / event-out bundle between the shaping filter, peak finder and readout.
interface v1_peak_finder_if
    import v1_param::*;
#(
    parameter int TS_WIDTH = SIZE_PEAK_TS
);

    logic signed [SIZE_FILTER_DATA-1:0] filter_data;
    logic                               peak_valid;
    logic signed [SIZE_FILTER_DATA-1:0] peak_amp;
    logic        [TS_WIDTH-1:0]         peak_time;
    logic                               peak_sat;
    logic                               peak_pileup;
    logic        [15:0]                 drop_cnt;

    modport master (
        output filter_data,
        input  peak_valid, peak_amp, peak_time, peak_sat, peak_pileup, drop_cnt
    );

    modport slave (
        input  filter_data,
        output peak_valid, peak_amp, peak_time, peak_sat, peak_pileup, drop_cnt
    );

endinterface

// File: rtl/v1_peak_ts.sv
// Free-running sample timestamp; wraps at 2^TS_WIDTH, synchronous active-low clear.
module v1_peak_ts #(
    parameter int TS_WIDTH = 32
) (
    input  logic                clk,
    input  logic                i_clr_n,
    output logic [TS_WIDTH-1:0] o_ts
);

    logic [TS_WIDTH-1:0] r_ts;

    always_ff @(posedge clk) begin
        if (!i_clr_n) r_ts <= '0;
        else          r_ts <= r_ts + 1'b1;
    end

    assign o_ts = r_ts;

endmodule

// File: rtl/v1_peak_finder.sv
// Per-pulse amplitude/timestamp extractor behind the trapezoidal filter.
// Optional macro V1_PEAK_PILEUP_EN defers emission to the end of holdoff and flags pile-up.
module v1_peak_finder
    import v1_param::*;
#(
    parameter logic signed [SIZE_FILTER_DATA-1:0] THRESHOLD   = SIZE_FILTER_DATA'(100),
    parameter int                                 HOLDOFF_LEN = 32,
    parameter int                                 MAX_WIDTH   = 1024,
    parameter int                                 TS_WIDTH    = 32,
    parameter logic signed [SIZE_FILTER_DATA-1:0] SAT_LEVEL   = SIZE_FILTER_DATA'(65535)
) (
    input logic             clk,
    input logic             reset,
    v1_peak_finder_if.slave pk
);

    localparam int WW = $clog2(MAX_WIDTH + 1);
    localparam int HW = $clog2(HOLDOFF_LEN + 2);
    localparam logic [WW-1:0] MAX_W     = WW'(MAX_WIDTH);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_LEN);

    logic signed [SIZE_FILTER_DATA-1:0] r_sq, r_sprev, r_max, r_amp;
    logic        [TS_WIDTH-1:0]         r_sq_ts, r_max_ts, r_time;
    logic        [WW-1:0]               r_width;
    logic        [HW-1:0]               r_hold;
    logic                               r_valid, r_sat, r_pile;
    logic        [15:0]                 r_drop;
    peak_state_e                        r_state;

    peak_state_e                        w_state_nxt;
    logic signed [SIZE_FILTER_DATA-1:0] w_max_nxt;
    logic        [TS_WIDTH-1:0]         w_max_ts_nxt, w_ts;
    logic        [WW-1:0]               w_width_nxt, w_width_inc;
    logic        [HW-1:0]               w_hold_nxt;
    logic                               w_above, w_cross, w_end, w_drop, w_emit, w_pile;

    v1_peak_ts #(.TS_WIDTH(TS_WIDTH)) u_ts (
        .clk     (clk),
        .i_clr_n (reset),
        .o_ts    (w_ts)
    );

    assign w_above     = r_sq > THRESHOLD;
    assign w_cross     = (r_sprev <= THRESHOLD) && w_above;
    assign w_width_inc = r_width + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_max_nxt    = r_max;
        w_max_ts_nxt = r_max_ts;
        w_width_nxt  = r_width;
        w_hold_nxt   = r_hold;
        w_end        = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cross) begin
                    w_state_nxt  = ARMED;
                    w_max_nxt    = r_sq;
                    w_max_ts_nxt = r_sq_ts;
                    w_width_nxt  = WW'(1);
                end
            end
            ARMED: begin
                // A below-threshold sample ends the pulse even on the timeout sample.
                if (!w_above) begin
                    w_state_nxt = HOLDOFF;
                    w_hold_nxt  = HOLD_INIT;
                    w_end       = 1'b1;
                end else begin
                    if (r_sq > r_max) begin
                        w_max_nxt    = r_sq;
                        w_max_ts_nxt = r_sq_ts;
                    end
                    w_width_nxt = w_width_inc;
                    if (w_width_inc >= MAX_W) begin
                        w_state_nxt = HOLDOFF;
                        w_hold_nxt  = HOLD_INIT;
                        w_drop      = 1'b1;
                    end
                end
            end
            HOLDOFF: begin
                if (r_hold == '0) w_state_nxt = IDLE;
                else              w_hold_nxt  = r_hold - 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef V1_PEAK_PILEUP_EN
    logic r_pend, r_pile_pend;
    logic w_hold_done;

    assign w_hold_done = (r_state == HOLDOFF) && (r_hold == '0);

    // r_pend separates a real pulse end from a timeout holdoff, which emits nothing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend      <= 1'b0;
            r_pile_pend <= 1'b0;
        end else if (w_end) begin
            r_pend      <= 1'b1;
            r_pile_pend <= 1'b0;
        end else if (w_hold_done) begin
            r_pend      <= 1'b0;
        end else if (r_state == HOLDOFF && w_cross) begin
            r_pile_pend <= 1'b1;
        end
    end

    assign w_emit = w_hold_done && r_pend;
    assign w_pile = r_pile_pend;
`else
    assign w_emit = w_end;
    assign w_pile = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sq     <= '0;
            r_sprev  <= '0;
            r_sq_ts  <= '0;
            r_max    <= '0;
            r_max_ts <= '0;
            r_width  <= '0;
            r_hold   <= '0;
            r_valid  <= 1'b0;
            r_amp    <= '0;
            r_time   <= '0;
            r_sat    <= 1'b0;
            r_pile   <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_sq     <= pk.filter_data;
            r_sprev  <= r_sq;
            r_sq_ts  <= w_ts;
            r_max    <= w_max_nxt;
            r_max_ts <= w_max_ts_nxt;
            r_width  <= w_width_nxt;
            r_hold   <= w_hold_nxt;
            r_valid  <= w_emit;
            if (w_emit) begin
                r_amp  <= r_max;
                r_time <= r_max_ts;
                r_sat  <= (r_max == SAT_LEVEL);
                r_pile <= w_pile;
            end
            if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
        end
    end

    assign pk.peak_valid  = r_valid;
    assign pk.peak_amp    = r_amp;
    assign pk.peak_time   = r_time;
    assign pk.peak_sat    = r_sat;
    assign pk.peak_pileup = r_pile;
    assign pk.drop_cnt    = r_drop;

endmodule

// File: tb/tb_v1_peak_finder.sv
// Scoreboard bench for v1_peak_finder; honours V1_PEAK_PILEUP_EN when defined.
module tb_v1_peak_finder;
    import v1_param::*;

    localparam int HOLDOFF_LEN = 32;
`ifdef V1_PEAK_PILEUP_EN
    localparam int   LAT_EXTRA = HOLDOFF_LEN + 1;
    localparam logic PILE_EXP  = 1'b1;
`else
    localparam int   LAT_EXTRA = 0;
    localparam logic PILE_EXP  = 1'b0;
`endif

    typedef struct {
        int   amp;
        int   ts;
        logic sat;
        logic pile;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   tb_ts = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    v1_peak_finder_if #(.TS_WIDTH(32)) pk ();

    v1_peak_finder #(
        .THRESHOLD   (SIZE_FILTER_DATA'(100)),
        .HOLDOFF_LEN (HOLDOFF_LEN),
        .MAX_WIDTH   (1024),
        .TS_WIDTH    (32),
        .SAT_LEVEL   (SIZE_FILTER_DATA'(65535))
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pk    (pk.slave)
    );

    // Event monitor: every strobe must match the oldest expected pulse.
    always @(negedge clk) begin
        if (pk.peak_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got amp=%0d time=%0d sat=%b pile=%b, none expected",
                         pk.peak_amp, pk.peak_time, pk.peak_sat, pk.peak_pileup);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (pk.peak_amp !== SIZE_FILTER_DATA'(e.amp) || pk.peak_time !== 32'(e.ts) ||
                    pk.peak_sat !== e.sat || pk.peak_pileup !== e.pile) begin
                    errors++;
                    $display("FAIL event got amp=%0d time=%0d sat=%b pile=%b want amp=%0d time=%0d sat=%b pile=%b",
                             pk.peak_amp, pk.peak_time, pk.peak_sat, pk.peak_pileup,
                             e.amp, e.ts, e.sat, e.pile);
                end
            end
        end
    end

    task automatic drive(input int v);
        pk.filter_data = SIZE_FILTER_DATA'(v);
        @(posedge clk);
        #1;
        tb_ts++;
    endtask

    task automatic push(input int amp, input int ts, input logic sat, input logic pile);
        ev_t e;
        e.amp = amp; e.ts = ts; e.sat = sat; e.pile = pile;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        repeat (HOLDOFF_LEN + 20) drive(0);
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (pk.peak_valid !== 1'b0 || pk.peak_amp !== '0 || pk.peak_time !== '0 ||
            pk.peak_sat !== 1'b0 || pk.peak_pileup !== 1'b0 || pk.drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s got valid=%b amp=%0d time=%0d sat=%b pile=%b drop=%0d want all 0",
                     tag, pk.peak_valid, pk.peak_amp, pk.peak_time, pk.peak_sat,
                     pk.peak_pileup, pk.drop_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pk.filter_data = SIZE_FILTER_DATA'(777);
        repeat (4) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        reset = 1'b1;
        tb_ts = 0;
    endtask

    task automatic test_basic();
        int b;
        int seq[9] = '{0, 50, 150, 300, 500, 400, 200, 90, 0};
        b = tb_ts;
        push(500, b + 4, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(seq[i]);
        repeat (LAT_EXTRA) drive(0);
        checks++;
        if (pk.peak_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got %b want 0", pk.peak_valid);
        end
        drive(0);
        checks++;
        if (pk.peak_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency got valid=%b want 1", pk.peak_valid);
        end
        drive(0);
        checks++;
        if (pk.peak_valid !== 1'b0 || pk.peak_amp !== SIZE_FILTER_DATA'(500)) begin
            errors++;
            $display("FAIL basic_strobe_hold got valid=%b amp=%0d want valid=0 amp=500",
                     pk.peak_valid, pk.peak_amp);
        end
        settle();
    endtask

    task automatic test_flat_top();
        int b;
        int seq[6] = '{0, 200, 700, 700, 700, 50};
        b = tb_ts;
        push(700, b + 2, 1'b0, 1'b0);
        foreach (seq[i]) drive(seq[i]);
        settle();
    endtask

    task automatic test_saturation();
        int b;
        b = tb_ts;
        push(65535, b + 1, 1'b1, 1'b0);
        drive(0);
        repeat (10) drive(65535);
        drive(0);
        settle();
    endtask

    task automatic test_timeout();
        int b;
        drive(0);
        repeat (2000) drive(300);
        checks++;
        if (pk.drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL timeout_drop_cnt got %0d want 1", pk.drop_cnt);
        end
        checks++;
        if (pk.peak_amp !== SIZE_FILTER_DATA'(65535) || pk.peak_sat !== 1'b1) begin
            errors++;
            $display("FAIL timeout_outputs_held got amp=%0d sat=%b want amp=65535 sat=1",
                     pk.peak_amp, pk.peak_sat);
        end
        drive(50);
        b = tb_ts;
        push(300, b, 1'b0, 1'b0);
        repeat (5) drive(300);
        drive(50);
        settle();
        checks++;
        if (pk.drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL timeout_drop_stable got %0d want 1", pk.drop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int b;
        int s1[4] = '{0, 150, 250, 0};
        int s2[5] = '{0, 120, 130, 110, 0};
        b = tb_ts;
        push(250, b + 2, 1'b0, 1'b0);
        foreach (s1[i]) drive(s1[i]);
        settle();
        b = tb_ts;
        push(130, b + 2, 1'b0, 1'b0);
        foreach (s2[i]) drive(s2[i]);
        settle();
    endtask

    task automatic test_pileup();
        int b;
        int sa[5] = '{0, 200, 400, 200, 0};
        b = tb_ts;
        push(400, b + 2, 1'b0, PILE_EXP);
        foreach (sa[i]) drive(sa[i]);
        repeat (9) drive(0);
        drive(300);
        drive(500);
        drive(300);
        drive(0);
        settle();
    endtask

    task automatic test_reset_mid();
        drive(0);
        drive(200);
        drive(500);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero_outputs("reset_mid_outputs");
        @(posedge clk);
        #1;
        reset = 1'b1;
        tb_ts = 0;
        push(300, 1, 1'b0, 1'b0);
        drive(0);
        drive(300);
        drive(0);
        settle();
    endtask

    initial begin
        pk.filter_data = '0;
        test_reset();
        test_basic();
        test_flat_top();
        test_saturation();
        test_timeout();
        test_back_to_back();
        test_pileup();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d outstanding want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
